// File: rtl/bus_router_pkg.sv
// Shared types and default configuration for the bus slot router.
package bus_router_pkg;

    // Router FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Width of the slot index and the irq source field (up to 16 slots).
    localparam int SLOT_IDX_W = 4;

    // Default four-slot map: 16-byte windows starting at 0x9000.
    localparam logic [3:0][31:0] DEFAULT_SLOT_BASE = {
        32'h0000_9030, 32'h0000_9020, 32'h0000_9010, 32'h0000_9000
    };
    localparam logic [3:0][31:0] DEFAULT_SLOT_MASK = {4{32'h0000_FFF0}};

    // Read data returned on a decode miss or a timeout abort.
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // Bits needed to hold a count from 0 up to max_count inclusive.
    function automatic int counter_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational priority decode of an address against the slot base/mask map.
module bus_addr_decoder
    import bus_router_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NUM_SLOTS = 4,
    parameter logic [NUM_SLOTS-1:0][ADDR_W-1:0] SLOT_BASE = DEFAULT_SLOT_BASE,
    parameter logic [NUM_SLOTS-1:0][ADDR_W-1:0] SLOT_MASK = DEFAULT_SLOT_MASK
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic                  hit_o,
    output logic [SLOT_IDX_W-1:0] idx_o
);

    logic [NUM_SLOTS-1:0] match;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
        assign match[gi] = ((addr_i & SLOT_MASK[gi]) == SLOT_BASE[gi]);
    end

    // Scan from the top down so the lowest matching slot is the one kept.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o = 1'b1;
                idx_o = SLOT_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_slot_router.sv
// Routes CPU bus accesses to NUM_SLOTS peripheral slots with busy stall,
// access timeout, error response and slot IRQ aggregation.
module bus_slot_router
    import bus_router_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_SLOTS      = 4,
    parameter logic [NUM_SLOTS-1:0][ADDR_W-1:0] SLOT_BASE = DEFAULT_SLOT_BASE,
    parameter logic [NUM_SLOTS-1:0][ADDR_W-1:0] SLOT_MASK = DEFAULT_SLOT_MASK,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEFAULT_ERR_DATA)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      cpu_req_i,
    input  logic [ADDR_W-1:0]         cpu_address_i,
    input  logic                      cpu_we_i,
    input  logic [DATA_W/8-1:0]       cpu_be_i,
    input  logic [DATA_W-1:0]         cpu_data_i,
    output logic [DATA_W-1:0]         cpu_data_o,
    output logic                      cpu_halt_o,
    output logic                      err_o,
    output logic                      timeout_sticky_o,
    output logic [NUM_SLOTS-1:0]      slot_sel_o,
    output logic [NUM_SLOTS-1:0]      slot_we_o,
    output logic [ADDR_W-1:0]         slot_address_o,
    output logic [DATA_W/8-1:0]       slot_be_o,
    output logic [DATA_W-1:0]         slot_data_o,
    input  logic [NUM_SLOTS*DATA_W-1:0] slot_data_i,
    input  logic [NUM_SLOTS-1:0]      slot_busy_i,
    input  logic [NUM_SLOTS-1:0]      slot_irq_i,
    output logic                      irq_o,
    output logic [SLOT_IDX_W-1:0]     irq_src_o
);

    localparam int CNT_W = counter_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    logic [NUM_SLOTS-1:0]  sel_q, sel_d;
    logic [NUM_SLOTS-1:0]  we_q, we_d;
    logic                  halt_q, halt_d;
    logic                  err_q, err_d;
    logic                  sticky_q, sticky_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W/8-1:0]   be_q, be_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  irq_q, irq_d;
    logic [SLOT_IDX_W-1:0] irq_src_q, irq_src_d;

    logic                  dec_hit;
    logic [SLOT_IDX_W-1:0] dec_idx;
    logic [NUM_SLOTS-1:0]  dec_onehot;
    logic [DATA_W-1:0]     rd_mux;
    logic                  busy_sel;
    logic [CNT_W-1:0]      cnt_inc;

    bus_addr_decoder #(
        .ADDR_W    (ADDR_W),
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK)
    ) u_decoder (
        .addr_i (cpu_address_i),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_onehot
        assign dec_onehot[gi] = dec_hit && (dec_idx == SLOT_IDX_W'(gi));
    end

    // Only the selected slot's busy and read data matter; sel_q is one-hot.
    assign busy_sel = |(slot_busy_i & sel_q);

    // One-hot AND-OR mux of the selected slot's read data.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | slot_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Busy-wait counter step; holds at CNT_MAX instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Access FSM: accept in IDLE, stall while busy, commit or abort, one RESP cycle.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        halt_d   = halt_q;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    if (dec_hit) begin
                        addr_d  = cpu_address_i;
                        be_d    = cpu_be_i;
                        wdata_d = cpu_data_i;
                        sel_d   = dec_onehot;
                        we_d    = cpu_we_i ? dec_onehot : '0;
                        halt_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        rdata_d = ERR_DATA;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (!busy_sel) begin
                    // Commit cycle: a busy drop always beats a coincident timeout.
                    if (!(|we_q)) begin
                        rdata_d = rd_mux;
                    end
                    sel_d   = '0;
                    we_d    = '0;
                    halt_d  = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        rdata_d  = ERR_DATA;
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        sel_d    = '0;
                        we_d     = '0;
                        halt_d   = 1'b0;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // IRQ aggregation: any-asserted flag and lowest asserted index.
    always_comb begin
        irq_d     = |slot_irq_i;
        irq_src_d = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_irq_i[i]) begin
                irq_src_d = SLOT_IDX_W'(i);
            end
        end
    end

    // State registers; reset drops any active select immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            we_q      <= '0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
            irq_src_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
            irq_src_q <= irq_src_d;
        end
    end

    assign cpu_data_o       = rdata_q;
    assign cpu_halt_o       = halt_q;
    assign err_o            = err_q;
    assign timeout_sticky_o = sticky_q;
    assign slot_sel_o       = sel_q;
    assign slot_we_o        = we_q;
    assign slot_address_o   = addr_q;
    assign slot_be_o        = be_q;
    assign slot_data_o      = wdata_q;
    assign irq_o            = irq_q;
    assign irq_src_o        = irq_src_q;

endmodule

// File: doc/bus_slot_router.md
Name: bus_slot_router

Overview:
- Parametrised bus router between the RV32 CPU bus and NUM_SLOTS peripheral slots.
- Decodes the request address against a per-slot base/mask map and drives per-slot select and write strobes.
- Stalls the CPU with cpu_halt_o while the selected slot reports busy, and returns the registered read data.
- Adds an access timeout with error response and slot IRQ aggregation, which the fixed single-peripheral bus lacks.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- NUM_SLOTS, 4, number of peripheral slots (1..16).
- SLOT_BASE, package default map, NUM_SLOTS x ADDR_W base addresses.
- SLOT_MASK, package default map, NUM_SLOTS x ADDR_W decode masks.
- TIMEOUT_CYCLES, 255, maximum busy wait before abort (1..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on decode miss or timeout.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous active-high reset
- cpu_req_i  in  1  access strobe, sampled in IDLE only
- cpu_address_i  in  ADDR_W  access address
- cpu_we_i  in  1  1=write, 0=read
- cpu_be_i  in  DATA_W/8  byte enables for writes
- cpu_data_i  in  DATA_W  write data
- cpu_data_o  out  DATA_W  read data, registered
- cpu_halt_o  out  1  CPU stall
- err_o  out  1  one-cycle pulse on decode miss or timeout
- timeout_sticky_o  out  1  set on timeout; cleared only by reset
- slot_sel_o  out  NUM_SLOTS  one-hot slot select
- slot_we_o  out  NUM_SLOTS  one-hot write strobe
- slot_address_o  out  ADDR_W  registered address
- slot_be_o  out  DATA_W/8  registered byte enables
- slot_data_o  out  DATA_W  registered write data
- slot_data_i  in  NUM_SLOTS*DATA_W  per-slot read data; slot k occupies bits [k*DATA_W +: DATA_W]
- slot_busy_i  in  NUM_SLOTS  per-slot busy (plays the role module_busy_i plays on the single-peripheral bus)
- slot_irq_i  in  NUM_SLOTS  per-slot level IRQ
- irq_o  out  1  registered OR of slot_irq_i
- irq_src_o  out  4  lowest index with irq asserted, registered; 0 when none

Behaviour:
- Reset: async; all outputs 0, FSM to IDLE, timeout counter 0, any active select dropped immediately.
- Decode: slot k matches when (addr & SLOT_MASK[k]) == SLOT_BASE[k]; lowest matching index wins.
- FSM states IDLE, ACCESS, RESP.
- IDLE, cpu_req_i=1 at cycle N, address hits:
  - Register address, be and data.
  - At N+1: slot_sel_o[k]=1, slot_we_o[k]=cpu_we_i, cpu_halt_o=1; go to ACCESS.
- IDLE, decode miss:
  - At N+1: cpu_data_o=ERR_DATA, err_o=1 for one cycle, cpu_halt_o stays 0, state stays IDLE.
  - No slot strobe.
- ACCESS, slot_busy_i[k]=0 in a cycle:
  - That cycle is the commit cycle; the slot captures the write in it.
  - Next cycle: cpu_data_o <= slot_data_i[k] (reads only; writes leave cpu_data_o unchanged).
  - Next cycle: sel/we drop, cpu_halt_o=0, state RESP.
  - Minimum read latency: req at N, data valid and halt low at N+2.
- ACCESS, slot_busy_i[k]=1:
  - Hold sel, we, address and data stable; increment the timeout counter.
  - Counter reaching TIMEOUT_CYCLES while busy: next cycle cpu_data_o=ERR_DATA, err_o pulse, timeout_sticky_o=1, sel/we drop, halt drops, state RESP.
  - The write is not committed.
- Busy falling in the same cycle the counter hits TIMEOUT_CYCLES: commit wins; no error.
- RESP: one cycle; cpu_req_i ignored; return to IDLE. Back-to-back accesses are spaced at least 3 cycles.
- cpu_req_i asserted outside IDLE is ignored; the CPU holds its request while halted.
- Counter: clog2(TIMEOUT_CYCLES+1) bits; cleared on entry to ACCESS; saturates, never wraps.
- IRQ: irq_o and irq_src_o are registered one cycle after slot_irq_i; they are independent of the FSM.

Decomposition:
- Package bus_router_pkg holds:
  - the state enum;
  - default SLOT_BASE/SLOT_MASK arrays (slot 0 base 0x9000 mask 0xFFF0, slot 1 base 0x9010, slot 2 base 0x9020, slot 3 base 0x9030, mask 0xFFF0 throughout);
  - ERR_DATA;
  - a function computing counter width.
- Sub-module bus_addr_decoder: combinational priority decode producing hit and slot index. All sequential logic stays in bus_slot_router.

Test Plan:
- Read slot 1 (addr 0x9014, busy 0, slot_data 0x1234_5678): sel[1] high at N+1, cpu_data_o=0x1234_5678 and halt low at N+2.
- Write 0xA5A5_0001, be 4'b0011 to 0x9020, busy high for 5 cycles: sel[2]/we[2] held 6 cycles, halt high 6 cycles, slot sees data/be stable.
- Read 0x4000 (no match): no sel, err_o pulse at N+1, cpu_data_o=0xDEAD_BEEF, halt never high.
- TIMEOUT_CYCLES=8, slot 3 busy forever: halt drops after 8 busy cycles + 1, err_o pulse, timeout_sticky_o=1, cpu_data_o=0xDEAD_BEEF.
- TIMEOUT_CYCLES=8, busy falls exactly on cycle 8: normal completion, err_o=0, sticky stays 0.
- reset_i pulsed mid-ACCESS with busy high: sel/we/halt drop asynchronously; first request after release completes normally. Concurrently, slot_irq_i=4'b1010 gives irq_o=1 and irq_src_o=1 one cycle later.
